// File: rtl/sprite_pkg.sv
// Shared constants, coordinate type and pass-sequencer states for the sprite mask fetch block.
package sprite_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPR_DIM  = 32;
  localparam int ADDR_W   = 10;
  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/sprite_out_stage.sv
// Pixel output register. One cycle from load to out_valid.
// When out_valid is held and out_ready is low, advance drops and every output stays frozen.
module sprite_out_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_vld,
  input  logic [9:0] in_x,
  input  logic [9:0] in_y,
  input  logic [7:0] in_mask,
  input  logic       in_last,
  input  logic       out_ready,
  output logic       advance,
  output logic       out_valid,
  output logic [9:0] out_x,
  output logic [9:0] out_y,
  output logic [7:0] out_mask,
  output logic       out_last
);
  logic       out_valid_q, out_valid_d;
  logic [9:0] out_x_q, out_x_d;
  logic [9:0] out_y_q, out_y_d;
  logic [7:0] out_mask_q, out_mask_d;
  logic       out_last_q, out_last_d;

  assign advance = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_mask_d  = out_mask_q;
    out_last_d  = out_last_q;
    if (advance) begin
      out_valid_d = in_vld;
      out_last_d  = in_vld & in_last;
      if (in_vld) begin
        out_x_d    = in_x;
        out_y_d    = in_y;
        out_mask_d = in_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_mask_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_mask_q  <= out_mask_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_mask  = out_mask_q;
  assign out_last  = out_last_q;
endmodule

// File: rtl/sprite_mask_fetch.sv
// Streams a sprite mask from RAM as clipped screen pixels: first pixel 3 cycles after start, then one per
// cycle; a stalled output freezes RAM, counter and tags. SPRITE_MASK_SKIP_ZERO_EN also drops zero-mask pixels.
module sprite_mask_fetch #(
  parameter int SCREEN_W = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H = sprite_pkg::SCREEN_H,
  parameter int SPR_DIM  = sprite_pkg::SPR_DIM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] sprite_x,
  input  logic [9:0] sprite_y,
  output logic       busy,
  output logic       done,
  output logic [9:0] mem_address,
  output logic       mem_chipselect,
  output logic       mem_clken,
  input  logic [7:0] mem_readdata,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] out_x,
  output logic [9:0] out_y,
  output logic [7:0] out_mask,
  output logic       out_last
);
  import sprite_pkg::*;

  localparam int COL_W     = $clog2(SPR_DIM);
  localparam int LAST_ADDR = SPR_DIM * SPR_DIM - 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_valid_q, rd_valid_d;
  coord_t              spr_x_q, spr_x_d;
  coord_t              spr_y_q, spr_y_d;
  logic                done_q, done_d;

  logic                advance;
  logic [10:0]         pix_x, pix_y;
  logic                pix_keep;
  logic                rd_last;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = rd_valid_q;
    spr_x_d    = spr_x_q;
    spr_y_d    = spr_y_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        rd_valid_d = 1'b0;
        if (start) begin
          spr_x_d = sprite_x;
          spr_y_d = sprite_y;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (advance) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = cnt_q;
          cnt_d      = cnt_q + ADDR_W'(1);
          if (cnt_q == ADDR_W'(LAST_ADDR)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last pixel has left (or been dropped) once the tag is gone and the output can move.
        if (advance) begin
          rd_valid_d = 1'b0;
          if (!rd_valid_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      spr_x_q    <= '0;
      spr_y_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      spr_x_q    <= spr_x_d;
      spr_y_q    <= spr_y_d;
      done_q     <= done_d;
    end
  end

  // Sums are one bit wider than the screen coordinates so off-screen pixels clip instead of wrapping.
  assign pix_x   = {1'b0, spr_x_q} + 11'(rd_addr_q[COL_W-1:0]);
  assign pix_y   = {1'b0, spr_y_q} + 11'(rd_addr_q[ADDR_W-1:COL_W]);
  assign rd_last = (rd_addr_q == ADDR_W'(LAST_ADDR));

`ifdef SPRITE_MASK_SKIP_ZERO_EN
  assign pix_keep = (pix_x < 11'(SCREEN_W)) && (pix_y < 11'(SCREEN_H)) && (mem_readdata != 8'd0);
`else
  assign pix_keep = (pix_x < 11'(SCREEN_W)) && (pix_y < 11'(SCREEN_H));
`endif

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign mem_address    = cnt_q;
  assign mem_chipselect = busy;
  assign mem_clken      = busy & advance;

  sprite_out_stage u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .in_vld    (rd_valid_q & pix_keep),
    .in_x      (pix_x[9:0]),
    .in_y      (pix_y[9:0]),
    .in_mask   (mem_readdata),
    .in_last   (rd_last),
    .out_ready (out_ready),
    .advance   (advance),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_mask  (out_mask),
    .out_last  (out_last)
  );
endmodule

// File: tb/tb_sprite_mask_fetch.sv
// Bench for sprite_mask_fetch: table of sprite passes plus randomized passes, each pass checked
// against a per-address model of the pixel stream; hand sequences cover abort and start-while-busy.
module tb_sprite_mask_fetch;
  logic       clk, reset, start;
  logic [9:0] sprite_x, sprite_y;
  logic       busy, done;
  logic [9:0] mem_address;
  logic       mem_chipselect, mem_clken;
  logic [7:0] mem_readdata;
  logic       out_valid, out_ready;
  logic [9:0] out_x, out_y;
  logic [7:0] out_mask;
  logic       out_last;

  sprite_mask_fetch dut (
    .clk(clk), .reset(reset), .start(start), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_mask(out_mask), .out_last(out_last)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] m;
    logic       last;
  } pix_t;

  typedef struct {
    int  sx, sy;
    int  kind;      // 0: addr[7:0], 2: only 5 and 1023 nonzero, 3: constant 0xA5
    bit  rr;        // random out_ready
    int  tmode;     // 0 none, 1 done cycle, 2 first-valid and done cycle
    int  exp_cnt;
    int  exp_cnt_skip;
    int  exp_last;
  } vec_t;

  logic [7:0] ram [1024];
  pix_t got[$];
  pix_t expq[$];
  int   cyc, start_cyc, done_cyc, first_vld_cyc;
  int   done_cnt, stab_err, clk_err;
  int   n_tests, n_fail;
  bit   rdy_rand, prev_stall;
  pix_t prev_pix;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_chipselect && mem_clken) mem_readdata <= ram[mem_address];
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || pix_t'{out_x, out_y, out_mask, out_last} != prev_pix))
        stab_err++;
      if (out_valid && !out_ready && mem_clken) clk_err++;
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (out_valid && out_ready) got.push_back(pix_t'{out_x, out_y, out_mask, out_last});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_pix   = pix_t'{out_x, out_y, out_mask, out_last};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_ram(input int kind);
    for (int a = 0; a < 1024; a++) begin
      case (kind)
        0:       ram[a] = a[7:0];
        2:       ram[a] = (a == 5) ? 8'h5A : (a == 1023) ? 8'hC3 : 8'h00;
        3:       ram[a] = 8'hA5;
        default: ram[a] = 8'($urandom);
      endcase
    end
  endtask

  task automatic clear_mon();
    got.delete();
    done_cnt      = 0;
    stab_err      = 0;
    clk_err       = 0;
    first_vld_cyc = -1;
    done_cyc      = -1;
  endtask

  task automatic start_pass(input int sx, input int sy);
    @(posedge clk);
    #1;
    sprite_x  = 10'(sx);
    sprite_y  = 10'(sy);
    start     = 1'b1;
    start_cyc = cyc;
    clear_mon();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20000 && done_cnt == 0; k++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Expected stream straight from the pixel rules: row-major walk, clip to screen, optional zero skip.
  task automatic build_model(input int sx, input int sy);
    int x, y;
    bit keep;
    expq.delete();
    for (int a = 0; a < 1024; a++) begin
      x = sx + a % 32;
      y = sy + a / 32;
      keep = (x < 640) && (y < 480);
`ifdef SPRITE_MASK_SKIP_ZERO_EN
      keep = keep && (ram[a] != 8'd0);
`endif
      if (keep) expq.push_back(pix_t'{10'(x), 10'(y), ram[a], a == 1023});
    end
  endtask

  task automatic check_pass(input string name, input int sx, input int sy,
                            input int exp_cnt, input int exp_last);
    int errs, lastseen;
    build_model(sx, sy);
    errs = 0;
    lastseen = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (got[i].last) lastseen = 1;
      if (i >= expq.size() || got[i] != expq[i]) errs++;
    end
    chk({name, " count_vs_model"}, got.size(), expq.size());
    if (exp_cnt >= 0) chk({name, " count"}, got.size(), exp_cnt);
    chk({name, " pixel_errors"}, errs, 0);
    if (exp_last >= 0) chk({name, " out_last_seen"}, lastseen, exp_last);
    chk({name, " done_pulses"}, done_cnt, 1);
    chk({name, " stall_unstable"}, stab_err, 0);
    chk({name, " clken_in_stall"}, clk_err, 0);
  endtask

  vec_t vec[7];

  initial begin
    int sx, sy, n;
    pix_t p;
    n_tests = 0; n_fail = 0; cyc = 0;
    rdy_rand = 1'b0; prev_stall = 1'b0;
    reset = 1'b1; start = 1'b0; sprite_x = '0; sprite_y = '0;
    clear_mon();
    fill_ram(0);

    vec[0] = '{100, 50,  0, 1'b0, 1, 1024, 1020, 1};
    vec[1] = '{620, 470, 0, 1'b0, 0, 200,  198,  0};
    vec[2] = '{608, 448, 3, 1'b0, 2, 1024, 1024, 1};
    vec[3] = '{609, 449, 3, 1'b1, 0, 961,  961,  0};
    vec[4] = '{639, 479, 3, 1'b0, 0, 1,    1,    0};
    vec[5] = '{0,   0,   3, 1'b1, 0, 1024, 1024, 1};
    vec[6] = '{100, 50,  2, 1'b1, 0, 1024, 2,    1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_last", out_last, 0);
    chk("reset done", done, 0);
    chk("reset busy", busy, 0);
    chk("reset chipselect", mem_chipselect, 0);
    chk("reset clken", mem_clken, 0);
    chk("reset out_x", out_x, 0);
    chk("reset out_y", out_y, 0);
    chk("reset out_mask", out_mask, 0);
    chk("reset address", mem_address, 0);
    reset = 1'b0;

    foreach (vec[i]) begin
      fill_ram(vec[i].kind);
      rdy_rand = vec[i].rr;
      start_pass(vec[i].sx, vec[i].sy);
      chk($sformatf("vec%0d cycle1 address", i), mem_address, 0);
      chk($sformatf("vec%0d cycle1 chipselect", i), mem_chipselect, 1);
      chk($sformatf("vec%0d cycle1 busy", i), busy, 1);
      wait_done();
      rdy_rand = 1'b0;
`ifdef SPRITE_MASK_SKIP_ZERO_EN
      check_pass($sformatf("vec%0d", i), vec[i].sx, vec[i].sy, vec[i].exp_cnt_skip, vec[i].exp_last);
`else
      check_pass($sformatf("vec%0d", i), vec[i].sx, vec[i].sy, vec[i].exp_cnt, vec[i].exp_last);
`endif
      if (vec[i].tmode >= 1) chk($sformatf("vec%0d done_cycle", i), done_cyc - start_cyc, 1027);
      if (vec[i].tmode >= 2) chk($sformatf("vec%0d first_valid_cycle", i), first_vld_cyc - start_cyc, 3);
      chk($sformatf("vec%0d idle_after_done", i), busy, 0);
      if (i == 0 && got.size() > 0) begin
`ifdef SPRITE_MASK_SKIP_ZERO_EN
        p = pix_t'{10'd101, 10'd50, 8'h01, 1'b0};
`else
        p = pix_t'{10'd100, 10'd50, 8'h00, 1'b0};
`endif
        chk("basic first_pixel", got[0], p);
        p = pix_t'{10'd131, 10'd81, 8'hFF, 1'b1};
        chk("basic last_pixel", got[got.size()-1], p);
      end
    end

    for (int r = 0; r < 4; r++) begin
      fill_ram(1);
      sx = $urandom_range(0, 700);
      sy = $urandom_range(0, 520);
      rdy_rand = 1'b1;
      start_pass(sx, sy);
      wait_done();
      rdy_rand = 1'b0;
      check_pass($sformatf("rand%0d", r), sx, sy, -1, -1);
    end

    // Abort mid-pass, then restart in the first cycle after reset drops.
    fill_ram(0);
    start_pass(100, 50);
    for (int k = 0; k < 5000 && got.size() < 300; k++) @(posedge clk);
    chk("abort reached_pixel_300", got.size() >= 300, 1);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort no_done_pulse", done_cnt, 0);
    reset = 1'b0;
    start = 1'b1;
    sprite_x = 10'd200;
    sprite_y = 10'd100;
    start_cyc = cyc;
    clear_mon();
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart busy", busy, 1);
    wait_done();
    check_pass("restart", 200, 100, -1, -1);

    // A second start at cycle 10 must not disturb the pass in flight.
    fill_ram(1);
    start_pass(100, 50);
    while (cyc < start_cyc + 10) @(posedge clk);
    #1;
    sprite_x = 10'd300;
    sprite_y = 10'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    check_pass("start_while_busy", 100, 50, -1, 1);
    chk("start_while_busy done_cycle", done_cyc - start_cyc, 1027);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
